slice_feeder: RTL and testbench

SLICE_FEEDER -- requirements
Module: slice_feeder

---
 rtl/slice_feeder.sv | 134 +++++++++++++
 tb/tb_slice_feeder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/slice_feeder.sv
// ---------------------------------------------------------------------------
// slice_feeder
//   Holds DEPTH slices of WIDTH bits (one 5x5 plane each) and streams them,
//   in index order, to a downstream parity stage as (current, previous)
//   pairs, where previous is the slice at (idx-1) mod DEPTH.
//
//   Slices are loaded while idle. A start request walks the whole array once:
//   every index costs one FETCH cycle (register the pair) and at least one
//   PRESENT cycle (pair held until accepted).
//
// Ports
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-low reset (also clears the array)
//   wr_en      : slice write strobe, honoured only while idle
//   wr_addr    : slice index to write
//   wr_data    : slice value to write
//   start      : begin a pass over all slices (ignored while busy)
//   accept     : downstream takes the presented pair
//   curr_slice : slice at idx
//   pre_slice  : slice at (idx-1) mod DEPTH
//   valid      : pair presented and stable
//   idx        : index of the presented slice
//   busy       : high whenever not idle
//   done       : one-cycle pulse after the last slice is taken
// ---------------------------------------------------------------------------
module slice_feeder #(
    parameter  int WIDTH = 25,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic             accept,
    output logic [WIDTH-1:0] curr_slice,
    output logic [WIDTH-1:0] pre_slice,
    output logic             valid,
    output logic [AW-1:0]    idx,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic [AW-1:0]               r_idx;
    logic [AW-1:0]               w_idx_nxt;
    logic [AW-1:0]               w_pre_idx;
    logic [WIDTH-1:0]            r_curr;
    logic [WIDTH-1:0]            r_pre;
    logic                        w_last;

    assign w_last    = (r_idx == AW'(DEPTH - 1));
    // Explicit wrap so a non power-of-two DEPTH still points at the top slice.
    assign w_pre_idx = (r_idx == '0) ? AW'(DEPTH - 1) : r_idx - AW'(1);

    // Slice storage: writes only while idle, so a pass never disturbs it.
    // A write and a start in the same idle cycle both land; the write is
    // in the array one edge before the first FETCH reads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem <= '0;
        end else if (r_state == S_IDLE && wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = '0;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                if (accept) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_idx_nxt   = r_idx + AW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // The pair is captured only in FETCH, so it cannot move while PRESENT
    // waits on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_curr <= '0;
            r_pre  <= '0;
        end else if (r_state == S_FETCH) begin
            r_curr <= r_mem[r_idx];
            r_pre  <= r_mem[w_pre_idx];
        end
    end

    assign curr_slice = r_curr;
    assign pre_slice  = r_pre;
    assign idx        = r_idx;
    assign valid      = (r_state == S_PRESENT);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_slice_feeder.sv
module tb_slice_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [24:0] wr_data;
    logic        start;
    logic        accept;
    logic [24:0] curr_slice;
    logic [24:0] pre_slice;
    logic        valid;
    logic [5:0]  idx;
    logic        busy;
    logic        done;

    logic [24:0] model [64];
    int          n_tests = 0;
    int          n_fail  = 0;

    slice_feeder #(.WIDTH(25), .DEPTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .accept     (accept),
        .curr_slice (curr_slice),
        .pre_slice  (pre_slice),
        .valid      (valid),
        .idx        (idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One full pass with accept high except for an optional 10-cycle hold at
    // hold_at; optional start+write injection at inj_at; optional write of
    // slot 0 in the start cycle; optional start held high through DONE.
    task automatic run_pass(input int hold_at, input int inj_at, input bit wr0,
                            input bit hold_start, input int exp_lat);
        int n, vcnt, held, hcnt, nxt, pi;
        bit prev_v, inj_clr, inj_done;
        n = 0; vcnt = 0; held = 0; hcnt = 0; nxt = 0;
        prev_v = 1'b0; inj_clr = 1'b0; inj_done = 1'b0;
        accept = 1'b1;
        start  = 1'b1;
        if (wr0) begin
            wr_en = 1'b1; wr_addr = 6'd0; wr_data = 25'h0AAAAAA;
            model[0] = 25'h0AAAAAA;
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        chk("start_fetch", {valid, busy, idx}, {1'b0, 1'b1, 6'd0});
        while (!done && n < 400) begin
            tick();
            n++;
            if (inj_clr) begin
                start = 1'b0; wr_en = 1'b0; inj_clr = 1'b0;
            end
            if (valid) begin
                if (!prev_v) begin
                    chk("idx_seq", 64'(idx), 64'(nxt));
                    nxt++;
                    vcnt++;
                end
                pi = (int'(idx) + 63) % 64;
                chk("curr", 64'(curr_slice), 64'(model[idx]));
                chk("pre", 64'(pre_slice), 64'(model[pi]));
                if (int'(idx) == hold_at) hcnt++;
                if (int'(idx) == hold_at && held < 10) begin
                    accept = 1'b0;
                    held++;
                end else begin
                    accept = 1'b1;
                end
                if (int'(idx) == inj_at && !inj_done) begin
                    start = 1'b1; wr_en = 1'b1; wr_addr = 6'd3; wr_data = 25'h1FFFFFF;
                    inj_clr = 1'b1; inj_done = 1'b1;
                end
            end
            prev_v = valid;
        end
        chk("done_lat", 64'(n), 64'(exp_lat));
        chk("valid_cnt", 64'(vcnt), 64'd64);
        chk("hold_cnt", 64'(hcnt), (hold_at >= 0) ? 64'd11 : 64'd0);
        if (hold_start) start = 1'b1;
        tick();
        chk("done_pulse", {done, busy}, 2'b00);
    endtask

    initial begin
        int n;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; accept = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("rst_ctl", {valid, busy, done, idx}, 9'd0);
        chk("rst_curr", 64'(curr_slice), 64'd0);
        chk("rst_pre", 64'(pre_slice), 64'd0);
        @(negedge clk) rst = 1'b1;
        tick();

        // load slice k with k+1
        for (int k = 0; k < 64; k++) begin
            wr_en = 1'b1; wr_addr = 6'(k); wr_data = 25'(k + 1);
            model[k] = 25'(k + 1);
            tick();
        end
        wr_en = 1'b0;

        // plain pass, accept tied high: first pair (0,1,64), done at 128
        run_pass(-1, -1, 1'b0, 1'b0, 128);
        // backpressure at idx 5 for 10 cycles
        run_pass(5, -1, 1'b0, 1'b0, 138);
        // start and write to slot 3 mid-pass are ignored
        run_pass(-1, 20, 1'b0, 1'b0, 128);
        // second pass: slot 3 still holds 4
        run_pass(-1, -1, 1'b0, 1'b0, 128);
        // write slot 0 and start in the same idle cycle
        run_pass(-1, -1, 1'b1, 1'b0, 128);

        // asynchronous reset mid-pass at idx 40
        accept = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(valid && idx == 6'd40) && n < 200) begin
            tick();
            n++;
        end
        chk("reach40", {valid, idx}, {1'b1, 6'd40});
        #2 rst = 1'b0;
        #1;
        chk("async_ctl", {valid, busy, done, idx}, 9'd0);
        chk("async_curr", 64'(curr_slice), 64'd0);
        chk("async_pre", 64'(pre_slice), 64'd0);
        repeat (3) tick();
        chk("in_rst", {valid, busy, done}, 3'b000);
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 64; k++) model[k] = '0;

        // array cleared; start held high through DONE starts a new pass
        run_pass(-1, -1, 1'b0, 1'b1, 128);
        tick();
        chk("restart_fetch", {valid, busy, idx}, {1'b0, 1'b1, 6'd0});
        start = 1'b0;
        tick();
        chk("restart_valid", {valid, idx}, {1'b1, 6'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
